instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 169 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Single-stage instruction fetch unit. It keeps a program counter, reads one
// word per cycle from a combinational instruction memory, and presents the
// word to decode through a valid/ready output register. JAL targets are
// predecoded so the fetch stream follows unconditional jumps without a bubble.
// A fetch from beyond the end of memory, or a redirect to a misaligned
// address, raises a sticky fault. Only reset clears the fault.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   imem_addr   [31:0]: byte address to instruction memory (the PC register)
//   imem_rd     [31:0]: instruction word for imem_addr (combinational)
//   redirect          : taken branch/jump from downstream, flush and reload PC
//   redirect_target   : new byte PC, valid with redirect
//   if_ready          : decode accepts the presented instruction this cycle
//   if_valid          : if_instr / if_pc / if_pc_plus4 are valid
//   if_instr    [31:0]: fetched instruction word
//   if_pc       [31:0]: byte address of if_instr
//   if_pc_plus4 [31:0]: if_pc + 4 (link value)
//   fault             : sticky out-of-range / misaligned fetch flag
//   fetch_count [15:0]: saturating count of accepted instructions
//   dbg_state         : current FSM state (0 = RUN, 1 = FAULT)
//
// Handshake: an instruction transfers on every rising edge where
// if_valid && if_ready are both high. While if_valid is high and if_ready is
// low, the presented instruction and its PC stay stable until accepted or
// flushed by redirect.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fault,
    output logic [15:0] fetch_count,
    output logic        dbg_state
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);
    localparam logic [5:0]  OP_JAL     = 6'b000011;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic        fault_q, fault_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        is_jal;
    logic        pc_in_range;
    logic        handshake;
    logic        can_advance;

    assign pc_plus4    = pc_q + 32'd4;
    assign is_jal      = (imem_rd[31:26] == OP_JAL);
    // JAL target stays in the 256 MB region of the following instruction.
    assign next_pc     = is_jal ? {pc_plus4[31:28], imem_rd[25:0], 2'b00} : pc_plus4;
    assign pc_in_range = (pc_q[31:2] < IMEM_LIMIT);
    assign handshake   = if_valid_q && if_ready;
    // Output register is free when empty or being drained this cycle.
    assign can_advance = !if_valid_q || if_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        fault_d       = fault_q;

        // Accepted instructions count even when a redirect flushes the stage.
        if (handshake && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        // Misaligned target: PC is left where it was.
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!pc_in_range) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                    if (handshake) begin
                        if_valid_d = 1'b0;
                    end
                end else if (can_advance) begin
                    if_valid_d    = 1'b1;
                    if_instr_d    = imem_rd;
                    if_pc_d       = pc_q;
                    if_pc_plus4_d = pc_plus4;
                    pc_d          = next_pc;
                end
            end
            ST_FAULT: begin
                // Let any held instruction drain; redirect is ignored.
                if (if_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            fault_q       <= 1'b0;
            fetch_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A small instruction memory model
// answers imem_addr combinationally. Expected accepted instructions
// {instr, pc, pc_plus4} are queued by the stimulus thread; a negedge monitor
// pops and compares on every handshake. Point checks cover reset state,
// stalls, redirects and the fault behaviour.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fault;
    logic [15:0] fetch_count;
    logic        dbg_state;

    logic [31:0] mem [0:31];
    logic [95:0] exp_q [$];

    int total;
    int bad;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (20)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_ready        (if_ready),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .fault           (fault),
        .fetch_count     (fetch_count),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    always_comb begin
        if (imem_addr[31:2] < 30'd20) imem_rd = mem[imem_addr[6:2]];
        else                          imem_rd = 32'hDEAD_BEEF;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && if_valid === 1'b1 && if_ready === 1'b1) begin
            logic [95:0] exp_v;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL accept_unexpected: got instr=%h pc=%h pc4=%h, required no transfer",
                         if_instr, if_pc, if_pc_plus4);
            end else begin
                exp_v = exp_q.pop_front();
                if ({if_instr, if_pc, if_pc_plus4} !== exp_v) begin
                    bad++;
                    $display("FAIL accept_data: got instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                             if_instr, if_pc, if_pc_plus4, exp_v[95:64], exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    // Moves to the next cycle window: inputs change just after the rising
    // edge, and the task returns at the falling edge where outputs are checked.
    task automatic drive(input logic rst, input logic rdy, input logic rd, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset           = rst;
        if_ready        = rdy;
        redirect        = rd;
        redirect_target = tgt;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_acc(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        exp_q.push_back({instr, pc, pc4});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},  {31'h0, if_valid},    32'h0);
        check({tag, "_instr"},  if_instr,             32'h0);
        check({tag, "_pc"},     if_pc,                32'h0);
        check({tag, "_pc4"},    if_pc_plus4,          32'h0);
        check({tag, "_fault"},  {31'h0, fault},       32'h0);
        check({tag, "_count"},  {16'h0, fetch_count}, 32'h0);
        check({tag, "_addr"},   imem_addr,            32'h0);
        check({tag, "_state"},  {31'h0, dbg_state},   32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        if_ready        = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 + i;
        mem[0] = 32'h8C81_000C;
        mem[1] = 32'h8C80_0008;
        mem[7] = 32'h0C00_0005;   // jal -> 0x14

        // Reset
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check_reset_state("reset");

        // Expected accepted stream for the sequential / stall / jal / redirect run
        expect_acc(32'h8C81_000C, 32'h00, 32'h04);
        expect_acc(32'h8C80_0008, 32'h04, 32'h08);
        expect_acc(32'h2000_0002, 32'h08, 32'h0C);
        expect_acc(32'h2000_0003, 32'h0C, 32'h10);
        expect_acc(32'h2000_0004, 32'h10, 32'h14);
        expect_acc(32'h2000_0005, 32'h14, 32'h18);
        expect_acc(32'h2000_0006, 32'h18, 32'h1C);
        expect_acc(32'h0C00_0005, 32'h1C, 32'h20);
        expect_acc(32'h2000_0005, 32'h14, 32'h18);   // after jal
        expect_acc(32'h2000_0006, 32'h18, 32'h1C);   // after redirect to 0x18
        expect_acc(32'h0C00_0005, 32'h1C, 32'h20);   // accepted alongside redirect

        // Window 0: reset released, nothing valid yet
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("first_valid_low", {31'h0, if_valid}, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);               // w1: word0 accepted
        check("first_pc", if_pc, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);               // w2: word1 accepted

        // Windows 3..5: stall with word2 held
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check("stall_valid", {31'h0, if_valid},    32'h1);
            check("stall_instr", if_instr,             32'h2000_0002);
            check("stall_pc",    if_pc,                32'h08);
            check("stall_addr",  imem_addr,            32'h0C);
            check("stall_count", {16'h0, fetch_count}, 32'd2);
        end

        // Windows 6..12: stream through the jal and back to 0x14
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("after_jal_count", {16'h0, fetch_count}, 32'd8);

        // Window 13: stall with word6 @0x18 held
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_redir_pc", if_pc, 32'h18);
        // Window 14: redirect during stall
        drive(1'b0, 1'b0, 1'b1, 32'h18);
        check("redir_hold_valid", {31'h0, if_valid}, 32'h1);
        // Window 15: flushed bubble
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("redir_flush_valid", {31'h0, if_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h18);
        drive(1'b0, 1'b1, 1'b0, 32'h0);               // w16: 0x18 accepted
        // Window 17: handshake coincident with redirect to 0x40
        drive(1'b0, 1'b1, 1'b1, 32'h40);
        drive(1'b0, 1'b1, 1'b0, 32'h0);               // w18
        check("redir_hs_count", {16'h0, fetch_count}, 32'd11);
        check("redir_hs_valid", {31'h0, if_valid},    32'h0);
        check("redir_hs_addr",  imem_addr,            32'h40);

        // Range fault: words 16..19 then PC reaches 0x50
        expect_acc(32'h2000_0010, 32'h40, 32'h44);
        expect_acc(32'h2000_0011, 32'h44, 32'h48);
        expect_acc(32'h2000_0012, 32'h48, 32'h4C);
        expect_acc(32'h2000_0013, 32'h4C, 32'h50);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);               // w23
        check("range_fault",       {31'h0, fault},       32'h1);
        check("range_state",       {31'h0, dbg_state},   32'h1);
        check("range_valid",       {31'h0, if_valid},    32'h0);
        check("range_addr",        imem_addr,            32'h50);
        check("range_count",       {16'h0, fetch_count}, 32'd15);
        drive(1'b0, 1'b1, 1'b1, 32'h0);               // redirect ignored in FAULT
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("fault_redir_addr",  imem_addr,            32'h50);
        check("fault_redir_valid", {31'h0, if_valid},    32'h0);
        check("fault_sticky",      {31'h0, fault},       32'h1);

        // Reset clears everything
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check_reset_state("refault_reset");

        // Misaligned redirect while word0 is held
        drive(1'b0, 1'b0, 1'b0, 32'h0);               // w28: capture at next edge
        drive(1'b0, 1'b0, 1'b1, 32'h6);               // w29: word0 held, bad redirect
        check("mis_held_valid", {31'h0, if_valid}, 32'h1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);               // w30
        check("mis_fault",  {31'h0, fault},       32'h1);
        check("mis_state",  {31'h0, dbg_state},   32'h1);
        check("mis_addr",   imem_addr,            32'h04);
        check("mis_valid",  {31'h0, if_valid},    32'h0);
        check("mis_count",  {16'h0, fetch_count}, 32'd0);

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
